imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, byte-address width of requester address ports.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive lost cycles after which debug requester is forced a grant; legal range 1..15.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  CPU fetch request; held high until cpu_gnt.
REQ-007 cpu_addr  input  ADDR_WIDTH  CPU byte address; stable while cpu_req high.
REQ-008 cpu_gnt  output  1  combinational grant to CPU this cycle.
REQ-009 cpu_rvalid  output  1  registered; cpu_rdata valid this cycle.
REQ-010 cpu_rdata  output  DATA_WIDTH  read data returned to CPU.
REQ-011 dbg_req, dbg_addr, dbg_gnt, dbg_rvalid, dbg_rdata  same directions/widths as CPU ports  debug/loader requester.
REQ-012 mem_en  output  1  read strobe to shared single-port ROM.
REQ-013 mem_addr  output  ADDR_WIDTH-2  word address to ROM, equal to granted byte address bits [ADDR_WIDTH-1:2].
REQ-014 mem_data  input  DATA_WIDTH  ROM read data, valid exactly one cycle after mem_en.

Function
REQ-015 At most one of cpu_gnt, dbg_gnt SHALL be high in any cycle; mem_en SHALL equal cpu_gnt OR dbg_gnt.
REQ-016 FSM states: PRI_CPU (default) and FORCE_DBG.
REQ-017 PRI_CPU: cpu_req wins; dbg granted only when dbg_req high and cpu_req low.
REQ-018 FORCE_DBG: dbg_req wins unconditionally; CPU granted only if dbg_req low.
REQ-019 4-bit starve counter SHALL increment each cycle dbg_req is high and dbg_gnt low, and clear to 0 on any cycle dbg_gnt is high or dbg_req is low.
REQ-020 Transition PRI_CPU -> FORCE_DBG at the edge where counter would reach STARVE_LIMIT; FORCE_DBG -> PRI_CPU at the edge following any dbg_gnt or dbg_req low.
REQ-021 Owner tag (1 bit) and valid bit SHALL be registered on each grant; next cycle the owning requester's rvalid pulses high one cycle and its rdata equals mem_data; non-owner rvalid stays 0.
REQ-022 Read latency: grant in cycle N -> rvalid/rdata in cycle N+1; back-to-back grants every cycle SHALL be sustained (throughput 1 read/cycle).
REQ-023 rdata of a non-valid requester SHALL hold its last value (no change without rvalid).
REQ-024 cpu_addr/dbg_addr bits [1:0] SHALL be ignored.
REQ-025 Requester dropping req without grant SHALL not affect state other than REQ-019 counter clear.

Reset
REQ-026 While reset high: cpu_gnt, dbg_gnt, mem_en = 0; state = PRI_CPU; counter = 0; rvalid outputs = 0 next edge; rdata registers = 0.
REQ-027 Reset asserted in cycle following a grant SHALL suppress that grant's rvalid.
REQ-028 First grant possible in the first cycle reset is low.

Configuration
REQ-029 Macro IMEM_ARB_STATS_EN defined: adds outputs cpu_gnt_cnt and dbg_gnt_cnt (16 bits each), counting grants, saturating at 16'hFFFF, cleared by reset.
REQ-030 IMEM_ARB_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset release, cpu_req=1 cpu_addr=8'h10 every cycle, dbg idle -> cpu_gnt every cycle, mem_addr=6'h04, cpu_rvalid one cycle later with ROM word 4.
REQ-032 cpu_req and dbg_req both held, STARVE_LIMIT=4 -> 4 CPU grants, 5th cycle dbg_gnt=1, then CPU resumes; dbg_rvalid exactly once.
REQ-033 dbg_req only, dbg_addr=8'h23 -> dbg_gnt same cycle, mem_addr=6'h08, dbg_rvalid next cycle, cpu_rvalid=0 throughout.
REQ-034 Grant CPU in cycle N, reset=1 in N+1 -> cpu_rvalid=0 in N+1 and N+2, state PRI_CPU, counter 0.
REQ-035 Alternating grants CPU,DBG,CPU at addrs 0x00,0x04,0x08 -> rvalid routed CPU,DBG,CPU with words 0,1,2 in consecutive cycles.
REQ-036 With IMEM_ARB_STATS_EN, 70000 CPU grants -> cpu_gnt_cnt=16'hFFFF, dbg_gnt_cnt=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: two-requester (CPU, debug/loader) arbiter in front of a shared
// single-port instruction ROM with a one-cycle read latency.
//
// CPU normally wins. A 4-bit starve counter tracks consecutive cycles the debug
// requester asks without being served. When that count reaches STARVE_LIMIT, the
// arbiter switches to a forced-debug state for one grant and then falls back.
// Read data is routed to the granted requester one cycle after its grant. Each
// requester's rdata holds its last value between rvalid pulses.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   cpu_req/cpu_addr              CPU fetch request and byte address
//   cpu_gnt                       combinational grant to the CPU
//   cpu_rvalid/cpu_rdata          read return to the CPU
//   dbg_*                         the same set of ports for the debug/loader requester
//   mem_en/mem_addr/mem_data      ROM read strobe, word address, and read data
//                                 (read data arrives one cycle after mem_en)
//
// Optional feature: define IMEM_ARB_STATS_EN to add the saturating 16-bit grant
// counters cpu_gnt_cnt and dbg_gnt_cnt.
module imem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   input  logic                  dbg_req,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data
`ifdef IMEM_ARB_STATS_EN
   ,
   output logic [15:0]           cpu_gnt_cnt,
   output logic [15:0]           dbg_gnt_cnt
`endif
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned STAT_W = 16;

   typedef enum logic [0:0] {
      PRI_CPU   = 1'b0,
      FORCE_DBG = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_owner_q, rd_owner_d;   // 1 = debug owns the read in flight
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

   // Byte-offset bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[1:0], dbg_addr[1:0]};

   // Arbitration, starve tracking, and next-state logic.
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      cpu_gnt      = 1'b0;
      dbg_gnt      = 1'b0;

      if (!reset) begin
         case (state_q)
            PRI_CPU: begin
               cpu_gnt = cpu_req;
               dbg_gnt = dbg_req & ~cpu_req;
            end
            FORCE_DBG: begin
               dbg_gnt = dbg_req;
               cpu_gnt = cpu_req & ~dbg_req;
            end
            default: begin
               cpu_gnt = 1'b0;
               dbg_gnt = 1'b0;
            end
         endcase
      end

      // The counter saturates defensively, although the forced grant keeps it at or below the limit.
      if (dbg_req && !dbg_gnt) begin
         if (starve_cnt_q != {CNT_W{1'b1}}) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
         end
      end else begin
         starve_cnt_d = '0;
      end

      case (state_q)
         PRI_CPU: begin
            if (dbg_req && !dbg_gnt && (starve_cnt_d >= CNT_W'(STARVE_LIMIT))) begin
               state_d = FORCE_DBG;
            end
         end
         FORCE_DBG: begin
            if (dbg_gnt || !dbg_req) begin
               state_d = PRI_CPU;
            end
         end
         default: state_d = PRI_CPU;
      endcase
   end

   // ROM request path and read-return routing.
   always_comb begin
      mem_en     = cpu_gnt | dbg_gnt;
      mem_addr   = dbg_gnt ? dbg_addr[ADDR_WIDTH-1:2] : cpu_addr[ADDR_WIDTH-1:2];
      rd_valid_d = mem_en;
      rd_owner_d = dbg_gnt;

      // Reset in the return cycle suppresses a read that was granted just before it.
      cpu_rvalid = rd_valid_q & ~rd_owner_q & ~reset;
      dbg_rvalid = rd_valid_q &  rd_owner_q & ~reset;

      cpu_rdata_d = cpu_rvalid ? mem_data : cpu_rdata_q;
      dbg_rdata_d = dbg_rvalid ? mem_data : dbg_rdata_q;
      cpu_rdata   = cpu_rdata_d;
      dbg_rdata   = dbg_rdata_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PRI_CPU;
         starve_cnt_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_owner_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         rd_valid_q   <= rd_valid_d;
         rd_owner_q   <= rd_owner_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

`ifdef IMEM_ARB_STATS_EN
   logic [STAT_W-1:0] cpu_gnt_cnt_q, cpu_gnt_cnt_d;
   logic [STAT_W-1:0] dbg_gnt_cnt_q, dbg_gnt_cnt_d;

   // Saturating grant counters.
   always_comb begin
      cpu_gnt_cnt_d = cpu_gnt_cnt_q;
      dbg_gnt_cnt_d = dbg_gnt_cnt_q;
      if (cpu_gnt && (cpu_gnt_cnt_q != {STAT_W{1'b1}})) begin
         cpu_gnt_cnt_d = cpu_gnt_cnt_q + STAT_W'(1);
      end
      if (dbg_gnt && (dbg_gnt_cnt_q != {STAT_W{1'b1}})) begin
         dbg_gnt_cnt_d = dbg_gnt_cnt_q + STAT_W'(1);
      end
      cpu_gnt_cnt = cpu_gnt_cnt_q;
      dbg_gnt_cnt = dbg_gnt_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_gnt_cnt_q <= '0;
         dbg_gnt_cnt_q <= '0;
      end else begin
         cpu_gnt_cnt_q <= cpu_gnt_cnt_d;
         dbg_gnt_cnt_q <= dbg_gnt_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of arbitration and read return.
module tb_imem_arbiter;
   localparam int unsigned AW  = 8;
   localparam int unsigned DW  = 32;
   localparam int unsigned LIM = 4;
   localparam int unsigned MAW = AW - 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cpu_req = 1'b0, dbg_req = 1'b0;
   logic [AW-1:0]  cpu_addr = '0, dbg_addr = '0;
   logic           cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en;
   logic [DW-1:0]  cpu_rdata, dbg_rdata, mem_data;
   logic [MAW-1:0] mem_addr;
`ifdef IMEM_ARB_STATS_EN
   logic [15:0]    cpu_gnt_cnt, dbg_gnt_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
`ifdef IMEM_ARB_STATS_EN
      , .cpu_gnt_cnt(cpu_gnt_cnt), .dbg_gnt_cnt(dbg_gnt_cnt)
`endif
   );

   function automatic logic [DW-1:0] rom_word(input logic [MAW-1:0] w);
      return 32'hC0DE_0000 ^ (DW'(w) * 32'h0101_0101);
   endfunction

   // ROM: data for an enabled read arrives one cycle later; otherwise it is garbage.
   always @(posedge clk) mem_data <= mem_en ? rom_word(mem_addr) : DW'($urandom);

   // Behavioural model: the debug requester wins when the CPU is idle, or once it
   // has lost LIM consecutive cycles; each grant returns its ROM word to its owner next cycle.
   int            m_lost = 0;
   bit            m_pv = 0, m_po = 0;
   logic [DW-1:0] m_pw = '0, m_cl = '0, m_dl = '0;
   logic            e_cg, e_dg, e_cv, e_dv;
   logic [MAW-1:0]  e_ma;
   logic [DW-1:0]   e_cd, e_dd;

   task automatic cycle(input logic r, input logic cr, input logic [AW-1:0] ca,
                        input logic dr, input logic [AW-1:0] da);
      logic dwin, cwin;
      @(posedge clk);
      #1;
      reset = r; cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_addr = da;
      #3;
      dwin = !r && dr && (!cr || m_lost >= int'(LIM));
      cwin = !r && cr && !dwin;
      e_cg = cwin;
      e_dg = dwin;
      e_ma = dwin ? da[AW-1:2] : ca[AW-1:2];
      e_cv = !r && m_pv && !m_po;
      e_dv = !r && m_pv && m_po;
      e_cd = e_cv ? m_pw : m_cl;
      e_dd = e_dv ? m_pw : m_dl;
      m_cl   = r ? '0 : e_cd;
      m_dl   = r ? '0 : e_dd;
      m_pv   = cwin || dwin;
      m_po   = dwin;
      m_pw   = rom_word(e_ma);
      m_lost = r ? 0 : ((dr && !dwin) ? m_lost + 1 : 0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, 8'h10, 1'b1, 8'h20);
         n_cmp++;
         if ({cpu_gnt, dbg_gnt, mem_en} !== 3'b000) begin
            n_bad++; $display("FAIL reset_gnt: got %b want 000", {cpu_gnt, dbg_gnt, mem_en});
         end
      end
      n_cmp++;
      if ({cpu_rvalid, dbg_rvalid} !== 2'b00 || cpu_rdata !== '0 || dbg_rdata !== '0) begin
         n_bad++; $display("FAIL reset_rd: got rv=%b cd=%h dd=%h want 00/0/0",
                           {cpu_rvalid, dbg_rvalid}, cpu_rdata, dbg_rdata);
      end
   endtask

   task automatic test_cpu_stream();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
         n_cmp++;
         if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 6'h04) begin
            n_bad++; $display("FAIL cpu_stream_gnt[%0d]: got cg=%b dg=%b en=%b ma=%h want 1 0 1 04",
                              i, cpu_gnt, dbg_gnt, mem_en, mem_addr);
         end
         if (i > 0) begin
            n_cmp++;
            if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== rom_word(6'h04)) begin
               n_bad++; $display("FAIL cpu_stream_rd[%0d]: got cv=%b dv=%b cd=%h want 1 0 %h",
                                 i, cpu_rvalid, dbg_rvalid, cpu_rdata, rom_word(6'h04));
            end
         end
      end
   endtask

   task automatic test_starve();
      int dv_count = 0;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b1, 8'h40, (i <= 4), 8'h84);
         if (dbg_rvalid === 1'b1) dv_count++;
         n_cmp++;
         if (cpu_gnt !== (i != 4) || dbg_gnt !== (i == 4)) begin
            n_bad++; $display("FAIL starve_gnt[%0d]: got cg=%b dg=%b want %b %b",
                              i, cpu_gnt, dbg_gnt, i != 4, i == 4);
         end
         if (i == 4) begin
            n_cmp++;
            if (mem_addr !== 6'h21) begin
               n_bad++; $display("FAIL starve_addr: got %h want 21", mem_addr);
            end
         end
         if (i == 5) begin
            n_cmp++;
            if (dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== rom_word(6'h21)) begin
               n_bad++; $display("FAIL starve_rd: got dv=%b cv=%b dd=%h want 1 0 %h",
                                 dbg_rvalid, cpu_rvalid, dbg_rdata, rom_word(6'h21));
            end
         end
      end
      n_cmp++;
      if (dv_count != 1) begin
         n_bad++; $display("FAIL starve_dv_count: got %0d want 1", dv_count);
      end
   endtask

   task automatic test_dbg_only();
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h23);
         n_cmp++;
         if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_addr !== 6'h08 || cpu_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL dbg_only[%0d]: got dg=%b cg=%b ma=%h cv=%b want 1 0 08 0",
                              i, dbg_gnt, cpu_gnt, mem_addr, cpu_rvalid);
         end
         n_cmp++;
         if (dbg_rvalid !== (i > 0) || (i > 0 && dbg_rdata !== rom_word(6'h08))) begin
            n_bad++; $display("FAIL dbg_only_rd[%0d]: got dv=%b dd=%h want %b %h",
                              i, dbg_rvalid, dbg_rdata, i > 0, rom_word(6'h08));
         end
      end
   endtask

   task automatic test_reset_suppress();
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h0C, 1'b1, 8'h30);
      n_cmp++;
      if (cpu_gnt !== 1'b1) begin
         n_bad++; $display("FAIL rs_gnt: got %b want 1", cpu_gnt);
      end
      cycle(1'b1, 1'b1, 8'h0C, 1'b1, 8'h30);
      n_cmp++;
      if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b0) begin
         n_bad++; $display("FAIL rs_n1: got cv=%b cg=%b want 0 0", cpu_rvalid, cpu_gnt);
      end
      // A counter left over from before reset would let debug in early.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 8'h0C, 1'b1, 8'h30);
         if (i == 0) begin
            n_cmp++;
            if (cpu_rvalid !== 1'b0) begin
               n_bad++; $display("FAIL rs_n2: got cv=%b want 0", cpu_rvalid);
            end
         end
         n_cmp++;
         if (cpu_gnt !== (i != 4) || dbg_gnt !== (i == 4)) begin
            n_bad++; $display("FAIL rs_starve[%0d]: got cg=%b dg=%b want %b %b",
                              i, cpu_gnt, dbg_gnt, i != 4, i == 4);
         end
      end
   endtask

   task automatic test_alternate();
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
      n_cmp++;
      if (cpu_gnt !== 1'b1) begin
         n_bad++; $display("FAIL alt_c0: got cg=%b want 1", cpu_gnt);
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h04);
      n_cmp++;
      if (dbg_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== rom_word(6'd0)) begin
         n_bad++; $display("FAIL alt_d1: got dg=%b cv=%b dv=%b cd=%h want 1 1 0 %h",
                           dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, rom_word(6'd0));
      end
      cycle(1'b0, 1'b1, 8'h08, 1'b0, 8'h00);
      n_cmp++;
      if (cpu_gnt !== 1'b1 || dbg_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dbg_rdata !== rom_word(6'd1)) begin
         n_bad++; $display("FAIL alt_c2: got cg=%b dv=%b cv=%b dd=%h want 1 1 0 %h",
                           cpu_gnt, dbg_rvalid, cpu_rvalid, dbg_rdata, rom_word(6'd1));
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      n_cmp++;
      if (cpu_rvalid !== 1'b1 || dbg_rvalid !== 1'b0 || cpu_rdata !== rom_word(6'd2) || dbg_rdata !== rom_word(6'd1)) begin
         n_bad++; $display("FAIL alt_r3: got cv=%b dv=%b cd=%h dd=%h want 1 0 %h %h",
                           cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, rom_word(6'd2), rom_word(6'd1));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(39) == 0), 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom));
         n_cmp++;
         if (cpu_gnt !== e_cg || dbg_gnt !== e_dg || mem_en !== (e_cg | e_dg) ||
             ((e_cg | e_dg) && mem_addr !== e_ma)) begin
            n_bad++; $display("FAIL rand_gnt[%0d]: got cg=%b dg=%b en=%b ma=%h want %b %b %b %h",
                              i, cpu_gnt, dbg_gnt, mem_en, mem_addr, e_cg, e_dg, e_cg | e_dg, e_ma);
         end
         n_cmp++;
         if (cpu_rvalid !== e_cv || dbg_rvalid !== e_dv || cpu_rdata !== e_cd || dbg_rdata !== e_dd) begin
            n_bad++; $display("FAIL rand_rd[%0d]: got cv=%b dv=%b cd=%h dd=%h want %b %b %h %h",
                              i, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, e_cv, e_dv, e_cd, e_dd);
         end
      end
   endtask

`ifdef IMEM_ARB_STATS_EN
   task automatic test_stats();
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
      for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b1, AW'(i), 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      n_cmp++;
      if (cpu_gnt_cnt !== 16'hFFFF || dbg_gnt_cnt !== 16'h0000) begin
         n_bad++; $display("FAIL stats: got c=%h d=%h want ffff 0000", cpu_gnt_cnt, dbg_gnt_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_cpu_stream();
      test_starve();
      test_dbg_only();
      test_reset_suppress();
      test_alternate();
      test_random();
`ifdef IMEM_ARB_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
